// File: rtl/div_ctrl_pkg.sv
// Shared types for the iterative divide controller.
// Holds the FSM state encodings and the result bus width.
package div_ctrl_pkg;

   localparam int DIV_WIDTH     = 32;
   localparam int DIV_RESULT_WD = 64;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'b00,
      DIV_DIVZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring divide iteration, purely combinational.
// Ports: rem_in/quo_in/divisor in, rem_out/quo_out out.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // quo_in doubles as the dividend shift register: its MSB feeds
   // the partial remainder while quotient bits enter at the LSB.
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      if (trial[WIDTH]) begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end else begin
         rem_out = trial[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU controller for EX; stalls the pipe while busy.
// Ports: clk, rst, start, signed_div, opdata1/2, annul -> result, ready, stallreq.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stallreq
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;

   logic             s1;
   logic             s2;
   logic [WIDTH-1:0] op1_abs;
   logic [WIDTH-1:0] op2_abs;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign s1      = signed_div & opdata1[WIDTH-1];
   assign s2      = signed_div & opdata2[WIDTH-1];
   assign op1_abs = s1 ? -opdata1 : opdata1;
   assign op2_abs = s2 ? -opdata2 : opdata2;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .divisor (dvs),
      .rem_out (rem_nx),
      .quo_out (quo_nx)
   );

   assign q_fix = neg_q ? -quo_nx : quo_nx;
   assign r_fix = neg_r ? -rem_nx : rem_nx;

   assign ready    = (state == DIV_END);
   assign stallreq = start & ~ready & ~annul & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= DIV_IDLE;
         count  <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else begin
         unique case (state)
            DIV_IDLE: begin
               if (start && !annul) begin
                  if (opdata2 == '0) begin
                     state <= DIV_DIVZERO;
                  end else begin
                     rem   <= '0;
                     quo   <= op1_abs;
                     dvs   <= op2_abs;
                     neg_q <= s1 ^ s2;
                     neg_r <= s1;
                     count <= '0;
                     state <= DIV_ON;
                  end
               end
            end
            DIV_DIVZERO: begin
               if (annul || !start) begin
                  state <= DIV_IDLE;
               end else begin
                  result <= '0;
                  state  <= DIV_END;
               end
            end
            DIV_ON: begin
               if (annul || !start) begin
                  state <= DIV_IDLE;
               end else begin
                  rem   <= rem_nx;
                  quo   <= quo_nx;
                  count <= count + CW'(1);
                  if (count == LAST) begin
                     result <= {r_fix, q_fix};
                     state  <= DIV_END;
                  end
               end
            end
            DIV_END: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, scoreboard queue,
// plus annul, back-to-back and asynchronous reset sequences.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   div_ctrl #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .stallreq   (stallreq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t        vecs[11];
   logic [63:0] sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          last_ready = 0;
   int          t_prev = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b);
      start      = 1'b1;
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
   endtask

   // Caller is at the negedge of cycle 0 with start already high.
   task automatic wait_done(input int lat, input string name);
      logic [63:0] e;
      for (int c = 0; c <= lat + 5; c++) begin
         #1;
         chk({name, " stallreq"}, {63'd0, stallreq}, {63'd0, c < lat});
         if (ready) begin
            chk({name, " latency"}, 64'(c), 64'(lat));
            e = sb.pop_front();
            chk({name, " result"}, result, e);
            last_ready = cyc;
            start = 1'b0;
            return;
         end
         @(negedge clk);
      end
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no ready within %0d cycles", name, lat + 5);
      if (sb.size() > 0) void'(sb.pop_front());
      start = 1'b0;
   endtask

   task automatic run(input vec_t v, input string name);
      @(negedge clk);
      issue(v.sgn, v.a, v.b);
      sb.push_back(v.exp);
      wait_done(v.lat, name);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},               33};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33};
      vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0, 32'hFFFFFFFF},         33};
      vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0, 32'h80000000},         33};
      vecs[4]  = '{1'b0, 32'd5,          32'd0,        64'd0,                         2};
      vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},         33};
      vecs[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},        33};
      vecs[7]  = '{1'b0, 32'd0,          32'd5,        64'd0,                         33};
      vecs[8]  = '{1'b0, 32'd1000,       32'd3,        {32'd1, 32'd333},              33};
      vecs[9]  = '{1'b1, 32'hFFFFFFFB,   32'd0,        64'd0,                         2};
      vecs[10] = '{1'b0, 32'h12345678,   32'h100,      {32'h78, 32'h00123456},        33};

      rst = 1'b1;
      start = 1'b1;
      annul = 1'b0;
      signed_div = 1'b0;
      opdata1 = 32'd1;
      opdata2 = 32'd1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset result", result, 64'd0);
      chk("reset ready", {63'd0, ready}, 64'd0);
      chk("reset stallreq", {63'd0, stallreq}, 64'd0);
      chk("reset state", {62'd0, dut.state}, {62'd0, DIV_IDLE});
      start = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         if (i == 3) t_prev = last_ready;
         run(vecs[i], $sformatf("vec%0d", i));
         if (i == 3)
            chk("b2b ready spacing", 64'(last_ready - t_prev), 64'd34);
      end

      // annul in cycle 10 of DIVU 1000/3, restart in cycle 11
      @(negedge clk);
      issue(1'b0, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      annul = 1'b1;
      #1;
      chk("annul stallreq", {63'd0, stallreq}, 64'd0);
      @(negedge clk);
      annul = 1'b0;
      #1;
      chk("annul ready", {63'd0, ready}, 64'd0);
      chk("annul state", {62'd0, dut.state}, {62'd0, DIV_IDLE});
      chk("annul result kept", result, {32'h78, 32'h00123456});
      sb.push_back({32'd1, 32'd333});
      wait_done(33, "after annul");

      // asynchronous reset during cycle 20
      @(negedge clk);
      issue(1'b0, 32'd1000, 32'd3);
      repeat (20) @(negedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst ready", {63'd0, ready}, 64'd0);
      chk("arst stallreq", {63'd0, stallreq}, 64'd0);
      chk("arst result", result, 64'd0);
      chk("arst state", {62'd0, dut.state}, {62'd0, DIV_IDLE});
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post rst state", {62'd0, dut.state}, {62'd0, DIV_IDLE});
      chk("post rst ready", {63'd0, ready}, 64'd0);

      run('{1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33}, "post rst div");
      chk("scoreboard empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
